// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers,
// with per-requester message lock and a busy-detect timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ID_W         = 1,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_lock,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 TX_STATUS,
  output logic                 TX_EN,
  output logic [7:0]           UART_TXD
);

  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_n;
  logic [ID_W-1:0]    grant_n;
  logic               lock_active, lock_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [7:0]         txd_n;
  logic               tx_en_n, terr_n;
  logic [NUM_REQ-1:0] ack_n;

  logic               eff_lock, rr_found, win_ok;
  logic [ID_W-1:0]    idx, rr_win, win;
  logic [7:0]         win_byte;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state       <= IDLE;
      grant_id    <= ID_W'(NUM_REQ - 1);
      lock_active <= 1'b0;
      cnt         <= '0;
      UART_TXD    <= '0;
      TX_EN       <= 1'b0;
      ack         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      grant_id    <= grant_n;
      lock_active <= lock_n;
      cnt         <= cnt_n;
      UART_TXD    <= txd_n;
      TX_EN       <= tx_en_n;
      ack         <= ack_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_n  = grant_id;
    lock_n   = lock_active;
    cnt_n    = cnt;
    txd_n    = UART_TXD;
    tx_en_n  = 1'b0;
    ack_n    = '0;
    terr_n   = 1'b0;

    // A lock whose owner has let go of req_lock is released on this same
    // evaluation, so the round-robin result below is used immediately.
    eff_lock = lock_active && req_lock[grant_id];

    rr_found = 1'b0;
    rr_win   = grant_id;
    idx      = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((32'(grant_id) + i) % NUM_REQ);
      if (!rr_found && req[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end

    win    = eff_lock ? grant_id : rr_win;
    win_ok = eff_lock ? req[grant_id] : rr_found;

    win_byte = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == win) win_byte = req_data[8*j +: 8];
    end

    case (state)
      IDLE: begin
        lock_n = eff_lock;
        if (TX_STATUS && win_ok) begin
          grant_n    = win;
          txd_n      = win_byte;
          tx_en_n    = 1'b1;
          ack_n[win] = 1'b1;
          state_n    = SEND;
        end
      end
      SEND: begin
        lock_n  = req_lock[grant_id];
        cnt_n   = '0;
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!TX_STATUS) begin
          cnt_n   = '0;
          state_n = WAIT_DONE;
        end else if (cnt == CNT_LAST) begin
          terr_n  = 1'b1;
          lock_n  = 1'b0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (TX_STATUS) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model checked every
// cycle, a responsive UART stand-in, and literal checks on the directed scenarios.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;
  localparam int BUSY_TO = 16;

  logic               sysclk = 1'b0;
  logic               reset  = 1'b1;
  logic [NUM_REQ-1:0] req = '0, req_lock = '0;
  logic [15:0]        req_data = '0;
  logic [NUM_REQ-1:0] ack;
  logic [ID_W-1:0]    grant_id;
  logic               busy, timeout_err, TX_EN;
  logic               TX_STATUS = 1'b1;
  logic [7:0]         UART_TXD;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .BUSY_TIMEOUT(BUSY_TO)) dut (
    .sysclk(sysclk), .reset(reset), .req(req), .req_lock(req_lock), .req_data(req_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err),
    .TX_STATUS(TX_STATUS), .TX_EN(TX_EN), .UART_TXD(UART_TXD));

  always #5 sysclk = ~sysclk;

  int vectors = 0, miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART stand-in: mode 0 drops TX_STATUS 2 cycles after TX_EN for 10 cycles,
  // mode 1 never goes busy, mode 2 follows tx_manual.
  int   uart_mode = 0;
  logic tx_manual = 1'b1;
  int   ut = -1;
  always @(posedge sysclk) begin
    #2;
    if (TX_EN === 1'b1) ut = 0;
    else if (ut >= 0 && ut < 12) ut++;
    else ut = -1;
    case (uart_mode)
      0:       TX_STATUS = !(ut >= 2 && ut < 12);
      1:       TX_STATUS = 1'b1;
      default: TX_STATUS = tx_manual;
    endcase
  end

  // Reference model: transmitter is either free or owned by a transfer that is
  // strobing, waiting for busy (with a deadline) or waiting for done.
  int          cyc = 0;
  bit          m_valid = 0, m_active = 0, m_strobe = 0, m_locked = 0, m_txen = 0, m_terr = 0;
  int          m_owner = NUM_REQ - 1, m_wait_from = -1;
  logic [7:0]  m_txd = '0;
  logic [NUM_REQ-1:0] m_ack = '0;

  always @(posedge sysclk) begin : model
    int win, best, d;
    cyc++;
    m_txen = 0; m_ack = '0; m_terr = 0;
    if (reset) begin
      m_valid = 1; m_active = 0; m_strobe = 0; m_locked = 0;
      m_owner = NUM_REQ - 1; m_wait_from = -1; m_txd = '0;
    end else if (!m_active) begin
      m_locked = m_locked && req_lock[m_owner];
      win = -1;
      if (TX_STATUS && req != '0) begin
        if (m_locked) begin
          if (req[m_owner]) win = m_owner;
        end else begin
          best = NUM_REQ;
          for (int i = 0; i < NUM_REQ; i++) begin
            d = (i - m_owner - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (req[i] && d < best) begin best = d; win = i; end
          end
        end
      end
      if (win >= 0) begin
        m_owner = win; m_txd = req_data[8*win +: 8];
        m_active = 1; m_strobe = 1; m_txen = 1; m_ack[win] = 1'b1;
      end
    end else if (m_strobe) begin
      m_strobe = 0; m_locked = req_lock[m_owner]; m_wait_from = cyc;
    end else if (m_wait_from >= 0) begin
      if (!TX_STATUS) m_wait_from = -1;
      else if (cyc - m_wait_from == BUSY_TO) begin
        m_terr = 1; m_active = 0; m_locked = 0; m_wait_from = -1;
      end
    end else if (TX_STATUS) begin
      m_active = 0;
    end
  end

  int         ncyc = 0, txen_ncyc = -1, terr_ncyc = -1;
  logic [7:0] log_txd[$];
  int         log_id[$];

  always @(negedge sysclk) begin
    ncyc++;
    if (m_valid) begin
      cmp("tx_en",       32'(TX_EN),       32'(m_txen));
      cmp("ack",         32'(ack),         32'(m_ack));
      cmp("uart_txd",    32'(UART_TXD),    32'(m_txd));
      cmp("grant_id",    32'(grant_id),    32'(m_owner));
      cmp("busy",        32'(busy),        32'(m_active));
      cmp("timeout_err", 32'(timeout_err), 32'(m_terr));
    end
    if (TX_EN === 1'b1) begin
      log_txd.push_back(UART_TXD); log_id.push_back(int'(grant_id)); txen_ncyc = ncyc;
    end
    if (timeout_err === 1'b1) terr_ncyc = ncyc;
  end

  task automatic step();
    @(negedge sysclk); #1;
  endtask

  task automatic do_reset(input bit clear_req);
    step();
    reset = 1'b1;
    if (clear_req) begin req = '0; req_lock = '0; end
    step();
    reset = 1'b0;
  endtask

  task automatic wait_ack(input int i);
    for (int n = 0; n < 300; n++) begin
      step();
      if (ack[i] === 1'b1) return;
    end
    cmp("ack_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 300; n++) begin
      step();
      if (busy === 1'b0) return;
    end
    cmp("idle_timeout", 0, 1);
  endtask

  int t0, rise;

  initial begin
    // 1: single byte, one-cycle request-to-strobe latency
    do_reset(1);
    cmp("reset_gid", 32'(grant_id), 1);
    cmp("reset_busy", 32'(busy), 0);
    log_txd.delete(); log_id.delete();
    req_data[7:0] = 8'h41; req = 2'b01; t0 = ncyc;
    wait_ack(0);
    req = '0;
    cmp("t1_latency", 32'(txen_ncyc - t0), 1);
    cmp("t1_txd", 32'(log_txd[0]), 32'h41);
    wait_idle();

    // 2: contention alternates 0,1,0,1
    do_reset(1);
    log_txd.delete(); log_id.delete();
    req_data = 16'h2010; req = 2'b11;
    for (int n = 0; n < 400 && log_txd.size() < 4; n++) step();
    req = '0;
    cmp("t2_count", 32'(log_txd.size()), 4);
    cmp("t2_b0", 32'(log_txd[0]), 32'h10); cmp("t2_id0", 32'(log_id[0]), 0);
    cmp("t2_b1", 32'(log_txd[1]), 32'h20); cmp("t2_id1", 32'(log_id[1]), 1);
    cmp("t2_b2", 32'(log_txd[2]), 32'h10); cmp("t2_id2", 32'(log_id[2]), 0);
    cmp("t2_b3", 32'(log_txd[3]), 32'h20); cmp("t2_id3", 32'(log_id[3]), 1);
    wait_idle();

    // 3: locked three-byte message from requester 1, then requester 0
    do_reset(1);
    log_txd.delete(); log_id.delete();
    req_data[7:0] = 8'h55; req = 2'b01;
    wait_ack(0);
    req_data = 16'hA166; req = 2'b11; req_lock = 2'b10;
    wait_ack(1); req_data[15:8] = 8'hA2;
    wait_ack(1); req_data[15:8] = 8'hA3;
    wait_ack(1); req_lock = '0; req = 2'b01;
    wait_ack(0); req = '0;
    cmp("t3_count", 32'(log_txd.size()), 5);
    cmp("t3_b1", 32'(log_txd[1]), 32'hA1); cmp("t3_id1", 32'(log_id[1]), 1);
    cmp("t3_b2", 32'(log_txd[2]), 32'hA2); cmp("t3_id2", 32'(log_id[2]), 1);
    cmp("t3_b3", 32'(log_txd[3]), 32'hA3); cmp("t3_id3", 32'(log_id[3]), 1);
    cmp("t3_b4", 32'(log_txd[4]), 32'h66); cmp("t3_id4", 32'(log_id[4]), 0);
    wait_idle();

    // 4: transmitter never goes busy -> timeout, then normal service
    do_reset(1);
    log_txd.delete(); log_id.delete();
    uart_mode = 1; terr_ncyc = -1;
    req_data[7:0] = 8'h77; req = 2'b01;
    wait_ack(0); req = '0; t0 = txen_ncyc;
    for (int n = 0; n < 60 && terr_ncyc < 0; n++) step();
    cmp("t4_terr_delay", 32'(terr_ncyc - t0), 17);
    cmp("t4_busy_after", 32'(busy), 0);
    uart_mode = 0;
    req_data[15:8] = 8'h88; req = 2'b10;
    wait_ack(1); req = '0;
    cmp("t4_next_b", 32'(UART_TXD), 32'h88);
    cmp("t4_next_id", 32'(grant_id), 1);
    wait_idle();

    // 5: TX_STATUS low while requesting
    do_reset(1);
    log_txd.delete(); log_id.delete();
    uart_mode = 2; tx_manual = 1'b0;
    step(); step();
    req_data[7:0] = 8'h5A; req = 2'b01;
    for (int n = 0; n < 6; n++) step();
    cmp("t5_held_off", 32'(log_txd.size()), 0);
    tx_manual = 1'b1; rise = -1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (TX_STATUS === 1'b1 && rise < 0) rise = ncyc;
      if (TX_EN === 1'b1) break;
    end
    uart_mode = 0; req = '0;
    cmp("t5_after_rise", 32'(txen_ncyc - rise), 1);
    cmp("t5_txd", 32'(log_txd[0]), 32'h5A);
    wait_idle();

    // 6: reset while the UART is still shifting
    do_reset(1);
    log_txd.delete(); log_id.delete();
    req_data[7:0] = 8'h30; req = 2'b01;
    wait_ack(0);
    req_data = 16'h3231; req = 2'b11;
    for (int n = 0; n < 5; n++) step();
    cmp("t6_busy_before", 32'(busy), 1);
    do_reset(0);
    cmp("t6_busy", 32'(busy), 0);
    cmp("t6_txen", 32'(TX_EN), 0);
    cmp("t6_gid", 32'(grant_id), 1);
    wait_ack(0);
    cmp("t6_first", 32'(UART_TXD), 32'h31);
    wait_ack(1); req = '0;
    cmp("t6_second", 32'(UART_TXD), 32'h32);
    wait_idle();

    for (int n = 0; n < 4; n++) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
